read_pointer_manager: RTL and testbench
=======================================

// Module: read_pointer_manager
// PURPOSE
//  Read-side pointer control for the FIFO; the consumer-end counterpart of the write pointer manager.
//  Advances the read pointer on accepted read requests and raises empty and underflow flags.
//  Pipelines a data-valid strobe that matches the memory read latency.
//  Reports the fill level and counts underflow events.
//  Sits between the consumer and the FIFO memory read port; one clock domain (clk_read).
// PARAMETERS
//  PTR_WIDTH   4  pointer width; depth 2**PTR_WIDTH, usable capacity 2**PTR_WIDTH-1 (one slot kept open)
//  RD_LATENCY  1  memory read latency in clk_read cycles, range 1..4
//  UFC_WIDTH   8  width of the saturating underflow event counter
// PORTS
//  clk_read    in   1            read clock; all logic rising-edge
//  reset_n     in   1            asynchronous, active-low reset
//  req_read    in   1            consumer read request, sampled every cycle
//  ptr_write   in   PTR_WIDTH    write pointer, already stable in the clk_read domain at this port
//  ptr_read    out  PTR_WIDTH    current read pointer = memory read address
//  en_read     out  1            memory read enable (accepted read)
//  flag_empty  out  1            FIFO empty
//  flag_uf     out  1            underflow: last request was made while empty
//  rd_valid    out  1            memory read data valid, RD_LATENCY cycles after en_read
//  level       out  PTR_WIDTH    entries held = ptr_write - ptr_read, modulo 2**PTR_WIDTH
//  uf_count    out  UFC_WIDTH    number of rejected reads, saturating
// BEHAVIOUR
//  - Reset (asynchronous assert, any cycle, including mid-operation): ptr_read=0, flag_uf=0,
//    rd_valid=0, valid pipe cleared, uf_count=0. Combinational outputs follow from these values.
//    Reads in flight are discarded: no rd_valid is produced for them after reset.
//  - flag_empty = (ptr_write == ptr_read), combinational. This is the same convention as
//    full = (ptr_write+1 == ptr_read) on the write side.
//  - en_read = req_read & ~flag_empty, combinational. The memory is never read while empty.
//  - Accept (en_read=1): ptr_read <= ptr_read+1 (natural wrap 2**PTR_WIDTH-1 -> 0) and flag_uf <= 0.
//  - Reject (req_read=1 & flag_empty=1): ptr_read holds and flag_uf <= 1.
//    uf_count <= uf_count+1, saturating at all-ones.
//  - Idle (req_read=0): all state holds, including flag_uf. flag_uf is sticky until the next accepted read.
//  - rd_valid: a shift pipe RD_LATENCY flops deep, fed by en_read. It asserts exactly RD_LATENCY cycles
//    after each accept. Back-to-back accepts give back-to-back rd_valid.
//  - level = ptr_write - ptr_read in PTR_WIDTH-bit modular arithmetic, combinational, range 0..2**PTR_WIDTH-1.
//  - Simultaneous write and read: ptr_write changing in the same cycle has no effect on that cycle's decision.
//    The decision uses the ptr_write value present at the edge. A write into an empty FIFO makes
//    flag_empty fall in the cycle ptr_write changes.
//  - Last entry: an accept with level=1 makes flag_empty=1 on the next cycle. A request in that next
//    cycle is rejected and sets flag_uf.
// TESTING (PTR_WIDTH=4, RD_LATENCY=2)
//  1 Reset, ptr_write=0, req_read=1 for 3 cycles -> en_read=0, flag_empty=1, flag_uf=1 from cycle 1,
//    uf_count=3, ptr_read=0.
//  2 ptr_write=3, req_read=1 for 4 cycles -> en_read high for 3 cycles, ptr_read 1,2,3, rd_valid high
//    for 3 cycles starting 2 cycles after the first en_read. 4th request: flag_uf=1, uf_count+1.
//  3 Wrap: ptr_read=15, ptr_write=1, two reads -> ptr_read 0 then 1, flag_empty=1, flag_uf=0.
//  4 Level: ptr_write=2, ptr_read=14 -> level=4. Full case ptr_write=13, ptr_read=14 -> level=15.
//  5 Underflow recovery: flag_uf=1, then ptr_write+=1 and req_read=1 -> en_read=1, flag_uf=0 next
//    cycle, uf_count unchanged.
//  6 Reset asserted one cycle after en_read -> rd_valid stays 0 and all outputs hold their reset values.
//    uf_count saturation test with UFC_WIDTH=2: 5 rejects -> uf_count=3.

Source files
------------

// File: rtl/read_pointer_manager.sv
// Read-side FIFO pointer control: advances the read address on accepted requests,
// flags empty/underflow, tracks fill level and delays a data-valid strobe to match memory latency.
module read_pointer_manager #(
    parameter int PTR_WIDTH  = 4,
    parameter int RD_LATENCY = 1,
    parameter int UFC_WIDTH  = 8
) (
    input  logic                 clk_read,
    input  logic                 reset_n,
    input  logic                 req_read,
    input  logic [PTR_WIDTH-1:0] ptr_write,
    output logic [PTR_WIDTH-1:0] ptr_read,
    output logic                 en_read,
    output logic                 flag_empty,
    output logic                 flag_uf,
    output logic                 rd_valid,
    output logic [PTR_WIDTH-1:0] level,
    output logic [UFC_WIDTH-1:0] uf_count
);

    // Bit 0 is loaded by the accept; rd_valid taps the last stage.
    logic [RD_LATENCY-1:0] vld_pipe;

    assign flag_empty = (ptr_write == ptr_read);
    assign en_read    = req_read & ~flag_empty;
    assign level      = ptr_write - ptr_read;
    assign rd_valid   = vld_pipe[RD_LATENCY-1];

    always_ff @(posedge clk_read or negedge reset_n) begin
        if (!reset_n) begin
            ptr_read <= '0;
            flag_uf  <= 1'b0;
            uf_count <= '0;
        end else if (en_read) begin
            ptr_read <= ptr_read + 1'b1;
            flag_uf  <= 1'b0;
        end else if (req_read) begin
            // Rejected read: flag stays set until the next accept.
            flag_uf <= 1'b1;
            if (uf_count != '1)
                uf_count <= uf_count + 1'b1;
        end
    end

    always_ff @(posedge clk_read or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= en_read;
            for (int i = 1; i < RD_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

endmodule

// File: tb/tb_read_pointer_manager.sv
// Random + directed bench for read_pointer_manager: a reference model predicts the flags each cycle
// and queues the cycle at which every accepted read must surface on rd_valid.
module tb_read_pointer_manager;
    localparam int PW  = 4;
    localparam int LAT = 2;
    localparam int DEPTH = 1 << PW;

    logic          clk_read = 1'b0;
    logic          reset_n;
    logic          req_read;
    logic [PW-1:0] ptr_write;
    logic [PW-1:0] ptr_read, level, ptr_read_s, level_s;
    logic          en_read, flag_empty, flag_uf, rd_valid;
    logic          en_read_s, flag_empty_s, flag_uf_s, rd_valid_s;
    logic [7:0]    uf_count;
    logic [1:0]    uf_count_s;

    read_pointer_manager #(.PTR_WIDTH(PW), .RD_LATENCY(LAT), .UFC_WIDTH(8)) dut (
        .clk_read(clk_read), .reset_n(reset_n), .req_read(req_read), .ptr_write(ptr_write),
        .ptr_read(ptr_read), .en_read(en_read), .flag_empty(flag_empty), .flag_uf(flag_uf),
        .rd_valid(rd_valid), .level(level), .uf_count(uf_count));

    // Narrow counter instance, used only to observe saturation.
    read_pointer_manager #(.PTR_WIDTH(PW), .RD_LATENCY(LAT), .UFC_WIDTH(2)) dut_s (
        .clk_read(clk_read), .reset_n(reset_n), .req_read(req_read), .ptr_write(ptr_write),
        .ptr_read(ptr_read_s), .en_read(en_read_s), .flag_empty(flag_empty_s), .flag_uf(flag_uf_s),
        .rd_valid(rd_valid_s), .level(level_s), .uf_count(uf_count_s));

    always #5 clk_read = ~clk_read;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_q[$];          // cycle numbers at which rd_valid is due

    // Model state: total reads accepted since reset, write position, underflow bookkeeping.
    int rd_total, wr_pos, rejects;
    bit uf_m;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares rd_valid against the scoreboard every cycle, popping on each due entry.
    always @(posedge clk_read) begin
        bit due;
        #1;
        cyc++;
        due = (exp_q.size() > 0) && (exp_q[0] == cyc);
        chk("rd_valid", int'(rd_valid), int'(due));
        chk("rd_valid_s", int'(rd_valid_s), int'(due));
        if (due) void'(exp_q.pop_front());
    end

    task automatic model_reset();
        rd_total = 0; wr_pos = 0; rejects = 0; uf_m = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk_read);
        reset_n = 1'b0;
        model_reset();
        req_read = 1'b0; ptr_write = '0;
        #1;
        chk("rst ptr_read", int'(ptr_read), 0);
        chk("rst flag_uf", int'(flag_uf), 0);
        chk("rst rd_valid", int'(rd_valid), 0);
        chk("rst uf_count", int'(uf_count), 0);
        chk("rst flag_empty", int'(flag_empty), 1);
        chk("rst uf_count_s", int'(uf_count_s), 0);
        @(negedge clk_read);
        reset_n = 1'b1;
    endtask

    // One cycle: drive, check the combinational view against the model, then advance the model.
    task automatic step(input bit req, input int wp);
        int rp, fill;
        bit empty, acc;
        @(negedge clk_read);
        wr_pos    = wp % DEPTH;
        req_read  = req;
        ptr_write = PW'(wr_pos);
        #1;
        rp    = rd_total % DEPTH;
        fill  = (wr_pos - rp + DEPTH) % DEPTH;
        empty = (fill == 0);
        acc   = req && !empty;
        chk("ptr_read", int'(ptr_read), rp);
        chk("flag_empty", int'(flag_empty), int'(empty));
        chk("en_read", int'(en_read), int'(acc));
        chk("level", int'(level), fill);
        chk("flag_uf", int'(flag_uf), int'(uf_m));
        chk("uf_count", int'(uf_count), (rejects > 255) ? 255 : rejects);
        chk("uf_count_s", int'(uf_count_s), (rejects > 3) ? 3 : rejects);
        if (acc) begin
            exp_q.push_back(cyc + LAT);
            rd_total++;
            uf_m = 0;
        end else if (req) begin
            rejects++;
            uf_m = 1;
        end
    endtask

    initial begin
        reset_n = 1'b0; req_read = 1'b0; ptr_write = '0;
        model_reset();
        apply_reset();

        // Requests against an empty FIFO.
        repeat (3) step(1, 0);
        // Three entries, four requests: last one underflows.
        repeat (4) step(1, 3);
        // Walk the read pointer to 15, then wrap with two reads.
        repeat (12) step(1, 15);
        step(0, 1);
        repeat (3) step(1, 1);
        // Level boundary: 15 entries held, then drain fully plus one underflow.
        step(0, 0);
        repeat (16) step(1, 0);
        // Underflow recovery by a write.
        step(1, 1);
        step(0, 1);

        // Reset one cycle after an accept: the in-flight read must vanish.
        step(1, 3);
        apply_reset();
        repeat (4) step(0, 0);

        // Random traffic; writes never exceed capacity.
        for (int i = 0; i < 400; i++) begin
            int fill, adv;
            fill = (wr_pos - (rd_total % DEPTH) + DEPTH) % DEPTH;
            adv  = $urandom_range(0, 2);
            if (fill + adv > DEPTH - 1) adv = DEPTH - 1 - fill;
            step(($urandom_range(0, 99) < 60), wr_pos + adv);
            if (i == 200) apply_reset();
        end

        repeat (LAT + 2) step(0, wr_pos);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
